rom_stream: RTL and testbench

ROM_STREAM -- requirements
Module: rom_stream

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_core.sv | 50 +++++
 rtl/rom_stream.sv | 115 +++++++++++
 tb/tb_rom_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and default sizes for the ROM burst streamer.
package rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } rom_state_e;

  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned ROM_DEPTH  = 16;

endpackage

// File: rtl/rom_core.sv
// Synchronous ROM with a registered read port; contents come from INIT_DATA.
// With ROM_STREAM_PARITY_EN defined, a parity bit is registered alongside the data.
module rom_core #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 16,
  parameter logic [DATA_W-1:0] INIT_DATA [DEPTH] = '{default: '0},
  localparam int unsigned      ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
`ifdef ROM_STREAM_PARITY_EN
  ,
  output logic              dpar
`endif
);

  logic [DATA_W-1:0] dout_q, dout_d;

  // The read register is reset, the array itself is constant.
  always_comb begin
    dout_d = dout_q;
    if (rd_en) dout_d = INIT_DATA[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

`ifdef ROM_STREAM_PARITY_EN
  logic dpar_q, dpar_d;

  always_comb begin
    dpar_d = ^dout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dpar_q <= 1'b0;
    else        dpar_q <= dpar_d;
  end

  assign dpar = dpar_q;
`endif

endmodule

// File: rtl/rom_stream.sv
// Streams LEN consecutive ROM words starting at BASE (wrapping at DEPTH) over a valid/ready port.
// Optional DPAR output (even parity of DOUT) when ROM_STREAM_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for START; BUSY low
// FETCH | ROM read of addr_q in flight
// SEND  | DOUT valid, waiting for DREADY
// FIN   | one-cycle DONE pulse
module rom_stream
  import rom_pkg::*;
#(
  parameter int unsigned       DATA_W = ROM_DATA_W,
  parameter int unsigned       DEPTH  = ROM_DEPTH,
  parameter logic [DATA_W-1:0] INIT_DATA [DEPTH] = '{default: '0},
  localparam int unsigned      ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              DONE
`ifdef ROM_STREAM_PARITY_EN
  ,
  output logic              DPAR
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);

  rom_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_mod;
  logic              rd_en;

  // BASE is narrower than 2*DEPTH, so a single conditional subtract is a full modulo.
  assign base_mod = ({1'b0, BASE} >= DEPTH_W) ? (BASE - DEPTH_W[ADDR_W-1:0]) : BASE;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            addr_d  = base_mod;
            cnt_d   = LEN;
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (DREADY) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ONE_CNT) begin
            state_d = FIN;
          end else begin
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign DVALID = (state_q == SEND);
  assign DONE   = (state_q == FIN);

  rom_core #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_DATA(INIT_DATA)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .rd_en(rd_en),
    .addr (addr_q),
    .dout (DOUT)
`ifdef ROM_STREAM_PARITY_EN
    ,
    .dpar (DPAR)
`endif
  );

endmodule

// File: tb/tb_rom_stream.sv
// Self-checking bench for rom_stream on a 5-word ROM (non-power-of-two wrap, BASE modulo).
// Parity checks are included when ROM_STREAM_PARITY_EN is defined.
module tb_rom_stream;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 5;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] INIT [DEPTH] = '{8'd70, 8'd80, 8'd71, 8'd65, 8'd0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              START = 1'b0;
  logic [ADDR_W-1:0] BASE = '0;
  logic [ADDR_W:0]   LEN = '0;
  logic              DREADY = 1'b0;
  logic              BUSY, DVALID, DONE;
  logic [DATA_W-1:0] DOUT;
`ifdef ROM_STREAM_PARITY_EN
  logic              DPAR;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] rom_model [$];

  always #5 clk = ~clk;

  rom_stream #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_DATA(INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .START (START),
    .BASE  (BASE),
    .LEN   (LEN),
    .BUSY  (BUSY),
    .DOUT  (DOUT),
    .DVALID(DVALID),
    .DREADY(DREADY),
    .DONE  (DONE)
`ifdef ROM_STREAM_PARITY_EN
    ,
    .DPAR  (DPAR)
`endif
  );

  // Word i of a burst starting at base: modulo BASE, then modulo advance.
  function automatic logic [DATA_W-1:0] model_word(input int base, input int i);
    int idx;
    idx = ((base % DEPTH) + i) % DEPTH;
    return rom_model[idx];
  endfunction

  task automatic run_burst(input int base, input int len, input int min_stall,
                           input int max_stall, input bit noise);
    logic [DATA_W-1:0] exp;
    int k;
    @(negedge clk);
    START  = 1'b1;
    BASE   = base[ADDR_W-1:0];
    LEN    = len[ADDR_W:0];
    DREADY = 1'($urandom % 2);
    @(negedge clk);
    START = 1'b0;
    if (len == 0) begin
      vectors++;
      if (DONE !== 1'b1 || DVALID !== 1'b0 || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_len_fin: DONE=%b DVALID=%b BUSY=%b, want 1 0 1", DONE, DVALID, BUSY);
      end
      if (noise) START = 1'b1;
      @(negedge clk);
      START = 1'b0;
      vectors++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DVALID !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_len_idle: DONE=%b BUSY=%b DVALID=%b, want 0 0 0", DONE, BUSY, DVALID);
      end
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp = model_word(base, i);
      vectors++;
      if (DVALID !== 1'b0 || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_gap[%0d] base=%0d len=%0d: DVALID=%b BUSY=%b, want 0 1",
                 i, base, len, DVALID, BUSY);
      end
      if (noise) begin
        START = 1'($urandom % 2);
        BASE  = ADDR_W'($urandom);
        LEN   = (ADDR_W + 1)'($urandom);
      end
      @(negedge clk);
      vectors++;
      if (DVALID !== 1'b1 || DOUT !== exp) begin
        miscompares++;
        $display("FAIL word[%0d] base=%0d len=%0d: DVALID=%b DOUT=%0d, want 1 %0d",
                 i, base, len, DVALID, DOUT, exp);
      end
`ifdef ROM_STREAM_PARITY_EN
      vectors++;
      if (DPAR !== ^exp) begin
        miscompares++;
        $display("FAIL parity[%0d]: DPAR=%b for expected DOUT=%0d, want %b", i, DPAR, exp, ^exp);
      end
`endif
      k = $urandom_range(max_stall, min_stall);
      for (int s = 0; s < k; s++) begin
        DREADY = 1'b0;
        @(negedge clk);
        vectors++;
        if (DVALID !== 1'b1 || DOUT !== exp) begin
          miscompares++;
          $display("FAIL stall_hold[%0d] cycle %0d: DVALID=%b DOUT=%0d, want 1 %0d",
                   i, s, DVALID, DOUT, exp);
        end
      end
      DREADY = 1'b1;
      @(negedge clk);
      DREADY = 1'($urandom % 2);
    end
    START = 1'b0;
    vectors++;
    if (DONE !== 1'b1 || DVALID !== 1'b0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse base=%0d len=%0d: DONE=%b DVALID=%b BUSY=%b, want 1 0 1",
               base, len, DONE, DVALID, BUSY);
    end
    @(negedge clk);
    vectors++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || DVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_return: DONE=%b BUSY=%b DVALID=%b, want 0 0 0", DONE, BUSY, DVALID);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (BUSY !== 1'b0 || DVALID !== 1'b0 || DONE !== 1'b0 || DOUT !== '0) begin
      miscompares++;
      $display("FAIL reset_state: BUSY=%b DVALID=%b DONE=%b DOUT=%0d, want all 0",
               BUSY, DVALID, DONE, DOUT);
    end
`ifdef ROM_STREAM_PARITY_EN
    vectors++;
    if (DPAR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dpar: DPAR=%b, want 0", DPAR);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (BUSY !== 1'b0 || DVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: BUSY=%b DVALID=%b, want 0 0", BUSY, DVALID);
    end
  endtask

  task automatic test_basic;
    run_burst(0, 4, 0, 0, 1'b0);
  endtask

  task automatic test_wrap;
    run_burst(3, 4, 0, 1, 1'b0);
    run_burst(7, 3, 0, 0, 1'b0);
    run_burst(1, 12, 0, 1, 1'b0);
  endtask

  task automatic test_stall;
    run_burst(1, 3, 5, 5, 1'b0);
  endtask

  task automatic test_len_zero;
    run_burst(2, 0, 0, 0, 1'b0);
    run_burst(4, 0, 0, 0, 1'b1);
    run_burst(2, 5, 0, 2, 1'b1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    START  = 1'b1;
    BASE   = '0;
    LEN    = (ADDR_W + 1)'(4);
    DREADY = 1'b1;
    @(negedge clk);
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (DVALID !== 1'b1 || DOUT !== model_word(0, i)) begin
        miscompares++;
        $display("FAIL pre_reset_word[%0d]: DVALID=%b DOUT=%0d, want 1 %0d",
                 i, DVALID, DOUT, model_word(0, i));
      end
      @(negedge clk);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (BUSY !== 1'b0 || DVALID !== 1'b0 || DONE !== 1'b0 || DOUT !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: BUSY=%b DVALID=%b DONE=%b DOUT=%0d, want all 0",
               BUSY, DVALID, DONE, DOUT);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DVALID !== 1'b0) begin
        miscompares++;
        $display("FAIL no_resume cycle %0d: DONE=%b BUSY=%b DVALID=%b, want 0 0 0",
                 c, DONE, BUSY, DVALID);
      end
    end
    DREADY = 1'b0;
    run_burst(0, 4, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_burst($urandom_range(7, 0), $urandom_range(15, 0), 0, 3, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom_model = '{8'd70, 8'd80, 8'd71, 8'd65, 8'd0};
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
